// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions.
//   - NUM_ROUNDS, block/word types and the encryption FSM state enum
//   - RCON table indexed directly by round number (1..10)
//   - S-box table plus SubBytes, MixColumns and S-box helper functions
// Byte order: bits [0:7] of a block are byte 0. Bytes 0-3 form column 0.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef logic [0:127] block_t;
    typedef logic [0:31]  word_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // Padded to 16 entries so the 4-bit round counter can index it directly.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic block_t sub_bytes(input block_t s);
        block_t o;
        o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            o[8*i +: 8] = SBOX[s[8*i +: 8]];
        end
        return o;
    endfunction

    function automatic block_t mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[32*c      +: 8];
            a1 = s[32*c + 8  +: 8];
            a2 = s[32*c + 16 +: 8];
            a3 = s[32*c + 24 +: 8];
            o[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step, combinational.
//   i_key   [0:127]  current round key (words w0..w3)
//   i_rcon  [7:0]    round constant for the round being produced
//   o_key   [0:127]  next round key
module aes_key_step
    import aes_pkg::*;
(
    input  logic [0:127] i_key,
    input  logic [7:0]   i_rcon,
    output logic [0:127] o_key
);

    word_t w_w0, w_w1, w_w2, w_w3;
    word_t w_rot, w_temp;
    word_t w_n0, w_n1, w_n2, w_n3;

    always_comb begin
        w_w0 = i_key[0:31];
        w_w1 = i_key[32:63];
        w_w2 = i_key[64:95];
        w_w3 = i_key[96:127];

        // RotWord, SubWord, then fold rcon into the leading byte.
        w_rot  = {w_w3[8:31], w_w3[0:7]};
        w_temp = {sbox(w_rot[0:7]), sbox(w_rot[8:15]),
                  sbox(w_rot[16:23]), sbox(w_rot[24:31])} ^ {i_rcon, 24'h000000};

        // Each new word chains off the one just produced.
        w_n0 = w_w0 ^ w_temp;
        w_n1 = w_w1 ^ w_n0;
        w_n2 = w_w2 ^ w_n1;
        w_n3 = w_w3 ^ w_n2;

        o_key = {w_n0, w_n1, w_n2, w_n3};
    end

endmodule

// File: rtl/aes_shift_rows.sv
// aes_shift_rows: AES ShiftRows byte permutation (pure wiring).
//   i_data  [0:127]  state in, column-major bytes
//   o_data  [0:127]  state out; row r rotated left by r columns
module aes_shift_rows
    import aes_pkg::*;
(
    input  logic [0:127] i_data,
    output logic [0:127] o_data
);

    // Output byte (row r, col c) takes input byte (row r, col (c+r) mod 4).
    always_comb begin
        o_data = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o_data[8*(4*c + r) +: 8] = i_data[8*(4*((c + r) % 4) + r) +: 8];
            end
        end
    end

endmodule

// File: rtl/aes_enc_seq.sv
// aes_enc_seq: iterative AES-128 encryptor, one round per clock.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   plaintext/key handshake (ready only in IDLE)
//   in_text, in_key       plaintext and key, byte 0 in bits [0:7]
//   out_valid / out_ready ciphertext handshake (held in DONE)
//   out_text              ciphertext, same byte order
//   busy                  FSM not in IDLE
//   round                 current round counter (0 in IDLE, 10 in DONE)
// Transfer edge loads text^key; nine full rounds then one final round
// without MixColumns, so out_valid rises 10 edges after the transfer.
module aes_enc_seq #(
    parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_text,
    input  logic [0:127] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_text,
    output logic         busy,
    output logic [3:0]   round
);
    import aes_pkg::*;

    state_t     r_fsm;
    block_t     r_state;
    block_t     r_key;
    logic [3:0] r_round;

    block_t     w_sub;
    block_t     w_shift;
    block_t     w_mix;
    block_t     w_rk;
    block_t     w_next;
    logic [7:0] w_rcon;

    // Round datapath: SubBytes -> ShiftRows -> MixColumns (bypassed in FINAL).
    always_comb begin
        w_sub  = sub_bytes(r_state);
        w_mix  = mix_columns(w_shift);
        w_rcon = RCON[r_round];
        w_next = ((r_fsm == FINAL) ? w_shift : w_mix) ^ w_rk;
    end

    aes_shift_rows u_shift_rows (
        .i_data (w_sub),
        .o_data (w_shift)
    );

    aes_key_step u_key_step (
        .i_key  (r_key),
        .i_rcon (w_rcon),
        .o_key  (w_rk)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= IDLE;
            r_round <= '0;
            r_state <= '0;
            r_key   <= '0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        r_state <= in_text ^ in_key;
                        r_key   <= in_key;
                        r_round <= 4'd1;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    r_state <= w_next;
                    r_key   <= w_rk;
                    r_round <= r_round + 4'd1;
                    if (r_round == 4'(NUM_ROUNDS - 1)) begin
                        r_fsm <= FINAL;
                    end
                end
                FINAL: begin
                    r_state <= w_next;
                    r_key   <= w_rk;
                    r_fsm   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_round <= '0;
                        r_fsm   <= IDLE;
                    end
                end
                default: begin
                    r_fsm <= IDLE;
                end
            endcase
        end
    end

    // Outputs are direct decodes of flopped state; in_ready is also gated by
    // rst_n so it stays low for the whole reset pulse.
    always_comb begin
        in_ready  = rst_n && (r_fsm == IDLE);
        out_valid = (r_fsm == DONE);
        busy      = (r_fsm != IDLE);
        out_text  = r_state;
        round     = r_round;
    end

endmodule

// File: tb/tb_aes_enc_seq.sv
// tb_aes_enc_seq: self-checking bench for aes_enc_seq.
// Reference model builds its S-box from GF(2^8) inversion plus the affine
// map and runs a byte-array AES-128 with a full 44-word key expansion.
module tb_aes_enc_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_text;
    logic [0:127] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_text;
    logic         busy;
    logic [3:0]   round;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc   = 0;
    int unsigned xfer_cyc = 0;

    logic [7:0] sb [256];

    localparam logic [0:127] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [0:127] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [0:127] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [0:127] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_enc_seq #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .busy      (busy),
        .round     (round)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:127] ref_enc(input logic [0:127] key, input logic [0:127] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [0:127] res;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ 8'(w[i/4] >> (24 - 8*(i%4)));
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c + r] = s[4*((c + r) % 4) + r];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) a[r] = t[4*c + r];
                for (int r = 0; r < 4; r++) begin
                    if (rnd < 10)
                        s[4*c + r] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                    else
                        s[4*c + r] = a[r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ 8'(w[4*rnd + i/4] >> (24 - 8*(i%4)));
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic start(input logic [0:127] key, input logic [0:127] pt);
        int unsigned n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_xfer", in_ready, 1'b1);
        in_valid = 1'b1; in_key = key; in_text = pt;
        @(posedge clk); #1;
        xfer_cyc = cyc;
        in_valid = 1'b0;
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_text  = {$urandom, $urandom, $urandom, $urandom};
        chk("busy_after_xfer", busy, 1'b1);
        chk("round_after_xfer", round, 4'd1);
    endtask

    task automatic finish_blk(input logic [0:127] exp, input int unsigned hold, input string tag);
        int unsigned  n = 0;
        logic [0:127] snap;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, cyc - xfer_cyc, 10);
        chk({tag, "_text"}, out_text, exp);
        chk({tag, "_round_done"}, round, 4'd10);
        chk({tag, "_ready_done"}, in_ready, 1'b0);
        snap = out_text;
        for (int k = 0; k < int'(hold); k++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_text"}, out_text, snap);
            chk({tag, "_hold_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_after_hs"}, out_valid, 1'b0);
        chk({tag, "_round_idle"}, round, 4'd0);
        chk({tag, "_busy_idle"}, busy, 1'b0);
    endtask

    task automatic wait_round(input logic [3:0] r);
        int unsigned n = 0;
        while (round != r && n < 30) begin
            @(posedge clk); #1; n++;
        end
        chk("wait_round", round, r);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [0:127] k, p;
        logic [0:127] rec_txt [2];
        int unsigned  rec_cyc [2];
        int unsigned  got;
        int unsigned  t0;
        logic         seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_text = '0; in_key = '0;
        build_sbox();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_round", round, 4'd0);
        chk("rst_out_text", out_text, 128'h0);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", in_ready, 1'b1);

        // App. B with 5 cycles of backpressure in DONE
        start(KB, PB);
        finish_blk(CB, 5, "appB");

        // App. C.1
        start(KC, PC);
        finish_blk(CC, 0, "appC");

        // Busy ignore: foreign pulses at rounds 3 and 7
        start(KB, PB);
        wait_round(4'd3);
        in_valid = 1'b1; in_key = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1; in_valid = 1'b0;
        wait_round(4'd7);
        in_valid = 1'b1; in_text = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1; in_valid = 1'b0;
        finish_blk(CB, 1, "busy_ign");

        // Reset mid-run at round 5
        start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        wait_round(4'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_round", round, 4'd0);
        chk("midrst_out_text", out_text, 128'h0);
        chk("midrst_in_ready", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ready_after", in_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        chk("midrst_no_output", seen, 1'b0);
        start(KC, PC);
        finish_blk(CC, 0, "midrst_appC");

        // Back-to-back with in_valid and out_ready held high
        out_ready = 1'b1;
        in_valid = 1'b1; in_key = KB; in_text = PB;
        @(posedge clk); #1;
        t0 = cyc;
        in_key = KC; in_text = PC;
        got = 0;
        for (int i = 0; i < 40 && got < 2; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                rec_cyc[got] = cyc;
                rec_txt[got] = out_text;
                got++;
            end
        end
        in_valid = 1'b0;
        chk("b2b_count", got, 2);
        chk("b2b_first_lat", rec_cyc[0] - t0, 10);
        chk("b2b_spacing", rec_cyc[1] - rec_cyc[0], 12);
        chk("b2b_first_text", rec_txt[0], CB);
        chk("b2b_second_text", rec_txt[1], CC);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b_idle_after", busy, 1'b0);

        // Randomized blocks against the reference model
        for (int i = 0; i < 16; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            start(k, p);
            finish_blk(ref_enc(k, p), $urandom_range(0, 3), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
